regfile_multiport: RTL and testbench

// Parametrised register file generalising the 32x32, 2-read/1-write regfile:

---
 rtl/regfile_multiport.sv | 122 ++++++++++++
 tb/tb_regfile_multiport.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with write-to-read bypass, optional
// registered reads and a sequenced bulk-clear engine (one register per cycle).
module regfile_multiport #(
  parameter int WIDTH        = 32,
  parameter int ADDR_BITS    = 5,
  parameter int NUM_READ     = 2,
  parameter int NUM_WRITE    = 2,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1,
  parameter int READ_LATENCY = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_READ*ADDR_BITS-1:0]  ReadRegister,
  output logic [NUM_READ*WIDTH-1:0]      ReadData,
  input  logic [NUM_WRITE*ADDR_BITS-1:0] WriteRegister,
  input  logic [NUM_WRITE*WIDTH-1:0]     WriteData,
  input  logic [NUM_WRITE-1:0]           RegWrite,
  input  logic                          clear_req,
  output logic                          busy,
  output logic                          dbgState
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t               state, stateNext;
  logic [ADDR_BITS-1:0] clearPtr, clearPtrNext;
  logic [WIDTH-1:0]     regs [DEPTH];
  logic [NUM_WRITE-1:0] writeAccept;
  logic [NUM_READ*WIDTH-1:0] readNow;

  // clear_req/busy handshake: clear_req is sampled only while busy=0; a
  // sampled pulse raises busy on the next cycle and it stays high for exactly
  // DEPTH cycles. Requests seen while busy=1 are discarded, never queued.

  always_comb begin
    writeAccept = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      writeAccept[w] = RegWrite[w] && (state == IDLE) &&
                       !((ZERO_REG != 0) && (WriteRegister[w*ADDR_BITS +: ADDR_BITS] == '0));
    end
  end

  // Ascending port order makes the highest-index port win on collisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[clearPtr] <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (writeAccept[w])
          regs[WriteRegister[w*ADDR_BITS +: ADDR_BITS]] <= WriteData[w*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    stateNext    = state;
    clearPtrNext = clearPtr;
    case (state)
      IDLE: begin
        clearPtrNext = '0;
        if (clear_req) stateNext = CLEAR;
      end
      CLEAR: begin
        if (clearPtr == {ADDR_BITS{1'b1}}) begin
          stateNext    = IDLE;
          clearPtrNext = '0;
        end else begin
          clearPtrNext = clearPtr + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clearPtr <= '0;
    end else begin
      state    <= stateNext;
      clearPtr <= clearPtrNext;
    end
  end

  assign busy     = (state == CLEAR);
  assign dbgState = state;

  always_comb begin
    readNow = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      readNow[p*WIDTH +: WIDTH] = regs[ReadRegister[p*ADDR_BITS +: ADDR_BITS]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (writeAccept[w] &&
              (WriteRegister[w*ADDR_BITS +: ADDR_BITS] == ReadRegister[p*ADDR_BITS +: ADDR_BITS]))
            readNow[p*WIDTH +: WIDTH] = WriteData[w*WIDTH +: WIDTH];
        end
      end
      if ((ZERO_REG != 0) && (ReadRegister[p*ADDR_BITS +: ADDR_BITS] == '0))
        readNow[p*WIDTH +: WIDTH] = '0;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : gRegRead
      logic [NUM_READ*WIDTH-1:0] readQ;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) readQ <= '0;
        else       readQ <= readNow;
      end
      assign ReadData = readQ;
    end else begin : gCombRead
      assign ReadData = readNow;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default config plus BYPASS=0 and
// READ_LATENCY=1 instances sharing the same stimulus.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ReadRegister;
  logic [9:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [1:0]  RegWrite;
  logic        clear_req;

  logic [63:0] rdDef, rdNb, rdLat;
  logic        busyDef, busyNb, busyLat;
  logic        stDef, stNb, stLat;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  regfile_multiport dut (
    .clk(clk), .reset(reset), .ReadRegister(ReadRegister), .ReadData(rdDef),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .clear_req(clear_req), .busy(busyDef), .dbgState(stDef)
  );

  regfile_multiport #(.BYPASS(0)) dutNb (
    .clk(clk), .reset(reset), .ReadRegister(ReadRegister), .ReadData(rdNb),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .clear_req(clear_req), .busy(busyNb), .dbgState(stNb)
  );

  regfile_multiport #(.READ_LATENCY(1)) dutLat (
    .clk(clk), .reset(reset), .ReadRegister(ReadRegister), .ReadData(rdLat),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .clear_req(clear_req), .busy(busyLat), .dbgState(stLat)
  );

  function automatic logic [31:0] lane(input logic [63:0] bus, input int p);
    return bus[p*32 +: 32];
  endfunction

  task automatic setRead(input int p, input logic [4:0] a);
    ReadRegister[p*5 +: 5] = a;
  endtask

  task automatic setWrite(input int w, input logic en, input logic [4:0] a, input logic [31:0] d);
    RegWrite[w]            = en;
    WriteRegister[w*5 +: 5] = a;
    WriteData[w*32 +: 32]   = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ReadRegister = '0; WriteRegister = '0; WriteData = '0; RegWrite = '0; clear_req = 1'b0;

    // 1: reset state
    setRead(0, 5'd5); setRead(1, 5'd31);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd0", lane(rdDef, 0), 32'h0);
    check("rst_rd1", lane(rdDef, 1), 32'h0);
    check("rst_busy", {31'b0, busyDef}, 32'h0);
    check("rst_lat_rd0", lane(rdLat, 0), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_rd1", lane(rdDef, 1), 32'h0);

    // 2: same-address collision, higher port wins
    setRead(0, 5'd7);
    setWrite(0, 1'b1, 5'd7, 32'hDEADBEEF);
    setWrite(1, 1'b1, 5'd7, 32'h12345678);
    #1;
    check("coll_bypass", lane(rdDef, 0), 32'h12345678);
    check("coll_nobypass_old", lane(rdNb, 0), 32'h0);
    @(posedge clk); #1;
    RegWrite = '0;
    @(negedge clk);
    check("coll_rd", lane(rdDef, 0), 32'h12345678);
    check("coll_rd_nb", lane(rdNb, 0), 32'h12345678);
    check("coll_lat", lane(rdLat, 0), 32'h12345678);

    // 3: zero register ignores writes, including through bypass
    setWrite(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    setRead(1, 5'd0);
    #1;
    check("zero_bypass", lane(rdDef, 1), 32'h0);
    check("zero_bypass_nb", lane(rdNb, 1), 32'h0);
    @(posedge clk); #1;
    RegWrite = '0;
    @(negedge clk);
    check("zero_rd", lane(rdDef, 1), 32'h0);
    check("zero_lat", lane(rdLat, 1), 32'h0);

    // 4: bypass vs. no bypass
    setWrite(0, 1'b1, 5'd3, 32'hA5A5A5A5);
    setRead(0, 5'd3);
    #1;
    check("byp_same_cycle", lane(rdDef, 0), 32'hA5A5A5A5);
    check("nobyp_same_cycle", lane(rdNb, 0), 32'h0);
    @(posedge clk); #1;
    RegWrite = '0;
    @(negedge clk);
    check("nobyp_next_cycle", lane(rdNb, 0), 32'hA5A5A5A5);
    check("byp_lat", lane(rdLat, 0), 32'hA5A5A5A5);

    // 5: fill, bulk clear, dropped write mid-clear, ignored re-request
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      setWrite(0, 1'b1, 5'(i), 32'(i));
      @(posedge clk); #1;
    end
    RegWrite = '0;
    @(negedge clk);
    setRead(0, 5'd31);
    #1;
    check("fill_r31", lane(rdDef, 0), 32'd31);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (!busyDef) break;
      cnt++;
      if (cnt == 1) check("clear_state", {31'b0, stDef}, 32'h1);
      if (cnt == 5) begin
        setWrite(0, 1'b1, 5'd9, 32'h99);
        setRead(0, 5'd9);
        #1;
        check("clear_no_bypass", lane(rdDef, 0), 32'd9);
      end
      if (cnt == 6) begin
        check("clear_write_dropped", lane(rdDef, 0), 32'd9);
        RegWrite = '0;
      end
      if (cnt == 10) clear_req = 1'b1;
      if (cnt == 11) clear_req = 1'b0;
    end
    check("busy_cycles", 32'(cnt), 32'd32);
    for (int a = 0; a < 32; a++) begin
      setRead(0, 5'(a));
      #1;
      check($sformatf("cleared_r%0d", a), lane(rdDef, 0), 32'h0);
    end

    // 6: reset in the middle of a clear
    @(negedge clk);
    setWrite(0, 1'b1, 5'd20, 32'h55);
    @(posedge clk); #1;
    RegWrite = '0;
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    setRead(0, 5'd20);
    cnt = 0;
    while (cnt < 10) begin
      @(negedge clk);
      if (!busyDef) break;
      cnt++;
    end
    check("midclear_reached", 32'(cnt), 32'd10);
    check("midclear_r20_kept", lane(rdDef, 0), 32'h55);
    reset = 1'b1;
    #1;
    check("midclear_busy", {31'b0, busyDef}, 32'h0);
    check("midclear_state", {31'b0, stDef}, 32'h0);
    check("midclear_r20", lane(rdDef, 0), 32'h0);
    check("midclear_lat_r20", lane(rdLat, 0), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_rst_busy", {31'b0, busyDef}, 32'h0);
    check("after_rst_r20", lane(rdDef, 0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
